// File: rtl/alu_result_if.sv
// Handshake and operand bundle between the ALU units, the result stage and its consumer.
interface alu_result_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       alu_ctl;
    logic [WIDTH-1:0] and_y;
    logic [WIDTH-1:0] or_y;
    logic [WIDTH-1:0] xor_y;
    logic [WIDTH-1:0] nor_y;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH-1:0] sub_y;
    logic [WIDTH-1:0] slt_y;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             illegal;

    modport master (
        output alu_ctl, and_y, or_y, xor_y, nor_y, add_y, sub_y, slt_y,
        output in_valid, out_ready,
        input  in_ready, out_valid, result, zero, negative, illegal
    );

    modport slave (
        input  alu_ctl, and_y, or_y, xor_y, nor_y, add_y, sub_y, slt_y,
        input  in_valid, out_ready,
        output in_ready, out_valid, result, zero, negative, illegal
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU output stage: result select, zero/negative flags, 2-entry skid buffer.
//   state | meaning
//   EMPTY | no entry held, out_valid=0
//   ONE   | head holds the only entry
//   FULL  | head and skid both hold entries, in_ready=0
module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_result_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             negative;
        logic             illegal;
    } entry_t;

    state_t           state_q;
    entry_t           head_q;
    entry_t           skid_q;
    entry_t           entry_d;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [WIDTH-1:0] sel_val;
    logic             sel_ill;
    logic             accept;
    logic             pop;

    always_comb begin
        sel_val = '0;
        sel_ill = 1'b0;
        case (bus.alu_ctl)
            3'b000:  sel_val = bus.and_y;
            3'b001:  sel_val = bus.or_y;
            3'b010:  sel_val = bus.add_y;
            3'b011:  sel_val = bus.xor_y;
            3'b100:  sel_val = bus.nor_y;
            3'b110:  sel_val = bus.sub_y;
            3'b111:  sel_val = bus.slt_y;
            default: sel_ill = 1'b1;
        endcase
        entry_d.result   = sel_val;
        entry_d.zero     = (sel_val == '0);
        entry_d.negative = sel_val[WIDTH-1];
        entry_d.illegal  = sel_ill;
    end

    assign accept = bus.in_valid & in_ready_q;
    assign pop    = out_valid_q & bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    // in_ready is held low for the reset cycle itself and rises here
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        head_q      <= entry_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_q <= entry_d;
                    end else if (accept) begin
                        skid_q     <= entry_d;
                        in_ready_q <= 1'b0;
                        state_q    <= FULL;
                    end else if (pop) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_q     <= skid_q;
                        skid_q     <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = head_q.result;
    assign bus.zero      = head_q.zero;
    assign bus.negative  = head_q.negative;
    assign bus.illegal   = head_q.illegal;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and randomized checks of alu_result_stage against a queue-based FIFO model.
module tb_alu_result_stage;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         n;
        logic         il;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    exp_t q[$];
    exp_t last;
    logic m_in_ready;

    alu_result_if #(.WIDTH(W)) bus ();

    alu_result_stage #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ref_sel(input logic [2:0] ctl);
        exp_t e;
        e.il = 1'b0;
        case (ctl)
            3'd0: e.r = bus.and_y;
            3'd1: e.r = bus.or_y;
            3'd2: e.r = bus.add_y;
            3'd3: e.r = bus.xor_y;
            3'd4: e.r = bus.nor_y;
            3'd6: e.r = bus.sub_y;
            3'd7: e.r = bus.slt_y;
            default: begin
                e.r  = '0;
                e.il = 1'b1;
            end
        endcase
        e.z = (e.r == 0);
        e.n = e.r[W-1];
        return e;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step(input string tag);
        logic acc, pp;
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_in_ready = 1'b0;
            last = '{r: '0, z: 1'b0, n: 1'b0, il: 1'b0};
        end else begin
            acc = bus.in_valid && m_in_ready;
            pp  = (q.size() != 0) && bus.out_ready;
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(ref_sel(bus.alu_ctl));
            m_in_ready = (q.size() < 2);
            if (q.size() != 0) last = q[0];
        end
        #1;
        check({tag, ".in_ready"},  {31'd0, bus.in_ready},  {31'd0, m_in_ready});
        check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, (q.size() != 0)});
        check({tag, ".result"},    bus.result,             last.r);
        check({tag, ".zero"},      {31'd0, bus.zero},      {31'd0, last.z});
        check({tag, ".negative"},  {31'd0, bus.negative},  {31'd0, last.n});
        check({tag, ".illegal"},   {31'd0, bus.illegal},   {31'd0, last.il});
    endtask

    task automatic rand_buses();
        bus.and_y = $urandom;
        bus.or_y  = $urandom;
        bus.xor_y = $urandom;
        bus.nor_y = $urandom;
        bus.add_y = $urandom;
        bus.sub_y = $urandom;
        bus.slt_y = {31'd0, 1'($urandom_range(1))};
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        m_in_ready = 1'b0;
        last       = '{r: '0, z: 1'b0, n: 1'b0, il: 1'b0};
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_ctl   = 3'd0;
        rand_buses();

        // 1: reset two cycles, then idle
        step("rst0");
        step("rst1");
        reset = 1'b0;
        step("idle0");
        step("idle1");

        // 2: single NOR of zero passes straight through
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.alu_ctl   = 3'b100;
        bus.nor_y     = 32'h0000_0000;
        step("nor_zero");
        bus.in_valid = 1'b0;
        step("nor_drain");

        // 3: stalled consumer fills both entries; third request ignored
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.alu_ctl   = 3'b100;
        bus.nor_y     = 32'hFFFF_FFF0;
        step("fill_nor");
        bus.alu_ctl = 3'b010;
        bus.add_y   = 32'h0000_0005;
        step("fill_add");
        bus.alu_ctl = 3'b000;
        bus.and_y   = 32'h1234_5678;
        step("ignored");
        step("held_full");
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step("drain1");
        step("drain2");
        step("drain3");

        // 4: back-to-back streaming
        bus.alu_ctl  = 3'b110;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.sub_y = i;
            step("stream");
        end
        bus.in_valid = 1'b0;
        step("stream_end");

        // 5: illegal code, then SLT
        rand_buses();
        bus.alu_ctl  = 3'b101;
        bus.in_valid = 1'b1;
        step("illegal");
        bus.alu_ctl = 3'b111;
        bus.slt_y   = 32'd1;
        step("slt");
        bus.in_valid = 1'b0;
        step("slt_drain");

        // 6: reset while full discards both entries
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.alu_ctl   = 3'b011;
        rand_buses();
        step("f6a");
        rand_buses();
        step("f6b");
        reset = 1'b1;
        bus.out_ready = 1'b1;
        step("rst_full");
        reset = 1'b0;
        bus.in_valid = 1'b0;
        step("post_rst0");
        step("post_rst1");

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rand_buses();
            bus.alu_ctl   = 3'($urandom_range(7));
            bus.in_valid  = ($urandom_range(99) < 70);
            bus.out_ready = ($urandom_range(99) < 60);
            reset         = ($urandom_range(99) < 2);
            step("rand");
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
